// File: rtl/seg_pkg.sv
// seg_pkg: shared segment constants and the active-low hex glyph table
package seg_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G - SEG_A + 1;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
  localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: 4-bit nibble to active-low {g..a} segment pattern
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);
  assign seg[SEG_G:SEG_A] = HEX_SEG[nibble];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-seg scanner with frame-aligned updates; SEG_LZ_BLANK_EN enables leading-zero blanking
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 20000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [4*DIGITS-1:0]   upd_data,
  input  logic [DIGITS-1:0]     upd_dp,
  output logic [DIGITS-1:0]     digit_en,
  output logic [SEG_W-1:0]      seg,
  output logic                  seg_dp,
  output logic                  frame_tick
);
  localparam int IDX_W = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int PW    = $clog2(SCAN_DIV);
  logic [PW-1:0]         prescaler;
  logic [IDX_W-1:0]      idx;
  logic [4*DIGITS-1:0]   disp_data, pend_data;
  logic [DIGITS-1:0]     disp_dp, pend_dp;
  logic                  pend, tick, boundary, accept, blank;
  logic [SEG_W-1:0]      dec_seg;

  assign tick      = prescaler == PW'(SCAN_DIV - 1);
  assign boundary  = tick && idx == IDX_W'(DIGITS - 1);
  assign upd_ready = ~pend;
  assign accept    = upd_valid && upd_ready;

`ifdef SEG_LZ_BLANK_EN
  assign blank = idx != '0 && (disp_data >> (4 * idx)) == '0 && (disp_dp >> idx) == '0;
`else
  assign blank = 1'b0;
`endif

  seg_hex_decoder u_dec (
    .nibble (disp_data[4*idx +: 4]),
    .seg    (dec_seg)
  );

  // prescaler and digit index advance together; index wraps at the frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      idx       <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      idx       <= boundary ? '0 : tick ? idx + 1'b1 : idx;
    end
  end

  // updates are staged in pend and only reach the display at a frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_data <= '0;
      disp_dp   <= '0;
      pend      <= 1'b0;
      pend_data <= '0;
      pend_dp   <= '0;
    end else if (boundary && pend) begin
      disp_data <= pend_data;
      disp_dp   <= pend_dp;
      pend      <= 1'b0;
    end else if (accept && boundary) begin
      disp_data <= upd_data;
      disp_dp   <= upd_dp;
    end else if (accept) begin
      pend_data <= upd_data;
      pend_dp   <= upd_dp;
      pend      <= 1'b1;
    end
  end

  // registered pin drivers, one cycle behind the index and display state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_en   <= '1;
      seg        <= SEG_OFF;
      seg_dp     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      digit_en   <= ~(DIGITS'(1) << idx);
      seg        <= blank ? SEG_OFF : dec_seg;
      seg_dp     <= ~disp_dp[idx];
      frame_tick <= boundary;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized self-checking bench against a cycle-count reference model
module tb_seg_scan_ctrl;
  localparam int D = 8;
  localparam int S = 4;
  localparam int F = D * S;

  typedef struct packed {logic [31:0] d; logic [7:0] p;} upd_t;

  logic        clk = 0, rst_n = 0, upd_valid = 0;
  logic [31:0] upd_data = '0;
  logic [7:0]  upd_dp = '0;
  logic        upd_ready, seg_dp, frame_tick;
  logic [7:0]  digit_en;
  logic [6:0]  seg;

  int   errors = 0, checks = 0;
  upd_t q[$];
  bit   rnd = 0;

  int          cyc;
  logic [31:0] m_disp, m_pd;
  logic [7:0]  m_dp, m_pdp, e_en;
  logic [6:0]  e_seg;
  logic        m_pend, m_acc_last, e_dp, e_ft;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGITS(D), .SCAN_DIV(S)) dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_data(upd_data), .upd_dp(upd_dp), .digit_en(digit_en), .seg(seg),
    .seg_dp(seg_dp), .frame_tick(frame_tick)
  );

  function automatic logic [6:0] hexs(logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic int digit(int c);
    return (c / S) % D;
  endfunction

  function automatic logic [6:0] shown(int d, logic [31:0] data, logic [7:0] dp);
    logic [3:0] nib;
    nib = data[4*d +: 4];
`ifdef SEG_LZ_BLANK_EN
    if (d != 0 && (data >> (4 * d)) == 0 && (dp >> d) == 0) return 7'h7F;
`else
    if (dp === 8'hxx) return 7'h7F;
`endif
    return hexs(nib);
  endfunction

  // Reference: digit shown and frame edges follow from the cycle count since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0; m_disp <= '0; m_dp <= '0; m_pend <= 0; m_pd <= '0; m_pdp <= '0;
      m_acc_last <= 0; e_en <= 8'hFF; e_seg <= 7'h7F; e_dp <= 1; e_ft <= 0;
    end else begin
      e_en  <= ~(8'd1 << digit(cyc));
      e_seg <= shown(digit(cyc), m_disp, m_dp);
      e_dp  <= ~m_dp[digit(cyc)];
      e_ft  <= (cyc % F == F - 1);
      m_acc_last <= upd_valid && !m_pend;
      if (cyc % F == F - 1 && m_pend) begin
        m_disp <= m_pd; m_dp <= m_pdp; m_pend <= 0;
      end else if (upd_valid && !m_pend && cyc % F == F - 1) begin
        m_disp <= upd_data; m_dp <= upd_dp;
      end else if (upd_valid && !m_pend) begin
        m_pd <= upd_data; m_pdp <= upd_dp; m_pend <= 1;
      end
      cyc <= cyc + 1;
    end
  end

  task automatic stim();
    upd_t u;
    if (upd_valid && !m_acc_last) return;
    if (q.size() != 0) begin
      u = q.pop_front();
      upd_valid = 1; upd_data = u.d; upd_dp = u.p;
    end else begin
      upd_valid = rnd && $urandom_range(0, 5) == 0;
      upd_data = $urandom; upd_dp = 8'($urandom);
    end
  endtask

  task automatic test_reset();
    int ft_cnt = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({digit_en, seg, seg_dp, frame_tick, upd_ready} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: got en=%h seg=%h dp=%b ft=%b rdy=%b, expected en=ff seg=7f dp=1 ft=0 rdy=1",
               digit_en, seg, seg_dp, frame_tick, upd_ready);
    end
    rst_n = 1;
    repeat (2 * F + 8) begin
      @(negedge clk);
      checks++;
      if ({digit_en, seg, seg_dp, frame_tick, upd_ready} !== {e_en, e_seg, e_dp, e_ft, !m_pend}) begin
        errors++;
        $display("FAIL idle_scan cyc=%0d: got en=%h seg=%h dp=%b ft=%b rdy=%b, expected en=%h seg=%h dp=%b ft=%b rdy=%b",
                 cyc, digit_en, seg, seg_dp, frame_tick, upd_ready, e_en, e_seg, e_dp, e_ft, !m_pend);
      end
      ft_cnt += int'(frame_tick);
      stim();
    end
    checks++;
    if (ft_cnt != 2) begin
      errors++;
      $display("FAIL frame_tick_count: got %0d, expected 2", ft_cnt);
    end
  endtask

  task automatic test_update(string name, int start, upd_t a, upd_t b, bit two, int cycles);
    bit pushed = 0;
    repeat (cycles) begin
      @(negedge clk);
      checks++;
      if ({digit_en, seg, seg_dp, frame_tick, upd_ready} !== {e_en, e_seg, e_dp, e_ft, !m_pend}) begin
        errors++;
        $display("FAIL %s cyc=%0d: got en=%h seg=%h dp=%b ft=%b rdy=%b, expected en=%h seg=%h dp=%b ft=%b rdy=%b",
                 name, cyc, digit_en, seg, seg_dp, frame_tick, upd_ready, e_en, e_seg, e_dp, e_ft, !m_pend);
      end
      if (!pushed && cyc % F == start) begin
        q.push_back(a);
        if (two) q.push_back(b);
        pushed = 1;
      end
      stim();
    end
  endtask

  task automatic test_boundary();
    bit pushed = 0;
    int dips = 0;
    repeat (3 * F) begin
      @(negedge clk);
      checks++;
      if ({digit_en, seg, seg_dp, frame_tick, upd_ready} !== {e_en, e_seg, e_dp, e_ft, !m_pend}) begin
        errors++;
        $display("FAIL boundary_load cyc=%0d: got en=%h seg=%h dp=%b ft=%b rdy=%b, expected en=%h seg=%h dp=%b ft=%b rdy=%b",
                 cyc, digit_en, seg, seg_dp, frame_tick, upd_ready, e_en, e_seg, e_dp, e_ft, !m_pend);
      end
      if (pushed) dips += int'(!upd_ready);
      if (!pushed && cyc % F == F - 1) begin
        q.push_back('{32'h0F1E2D3C, 8'h81});
        pushed = 1;
      end
      stim();
    end
    checks++;
    if (dips != 0) begin
      errors++;
      $display("FAIL boundary_ready: upd_ready low for %0d cycles, expected 0", dips);
    end
  endtask

  task automatic test_async_reset();
    bit pushed = 0;
    repeat (F) begin
      @(negedge clk);
      if (!pushed && cyc % F == 12) begin
        q.push_back('{32'hDEADBEEF, 8'hFF});
        pushed = 1;
      end
      stim();
      if (m_pend) break;
    end
    checks++;
    if (!(m_pend && upd_ready === 1'b0)) begin
      errors++;
      $display("FAIL async_pending: got rdy=%b, expected 0 with an update pending", upd_ready);
    end
    #2 rst_n = 0; upd_valid = 0;
    #1 checks++;
    if ({digit_en, seg, seg_dp, frame_tick, upd_ready} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: got en=%h seg=%h dp=%b ft=%b rdy=%b, expected en=ff seg=7f dp=1 ft=0 rdy=1",
               digit_en, seg, seg_dp, frame_tick, upd_ready);
    end
    @(negedge clk);
    rst_n = 1;
    repeat (2 * F) begin
      @(negedge clk);
      checks++;
      if ({digit_en, seg, seg_dp, frame_tick, upd_ready} !== {e_en, e_seg, e_dp, e_ft, !m_pend}) begin
        errors++;
        $display("FAIL post_reset cyc=%0d: got en=%h seg=%h dp=%b ft=%b rdy=%b, expected en=%h seg=%h dp=%b ft=%b rdy=%b",
                 cyc, digit_en, seg, seg_dp, frame_tick, upd_ready, e_en, e_seg, e_dp, e_ft, !m_pend);
      end
      stim();
    end
  endtask

  task automatic test_random();
    rnd = 1;
    repeat (20 * F) begin
      @(negedge clk);
      checks++;
      if ({digit_en, seg, seg_dp, frame_tick, upd_ready} !== {e_en, e_seg, e_dp, e_ft, !m_pend}) begin
        errors++;
        $display("FAIL random cyc=%0d: got en=%h seg=%h dp=%b ft=%b rdy=%b, expected en=%h seg=%h dp=%b ft=%b rdy=%b",
                 cyc, digit_en, seg, seg_dp, frame_tick, upd_ready, e_en, e_seg, e_dp, e_ft, !m_pend);
      end
      stim();
    end
    rnd = 0;
  endtask

  initial begin
    test_reset();
    test_update("single_update", 10, '{32'h89ABCDEF, 8'h00}, '{32'h0, 8'h0}, 0, 3 * F);
    test_update("held_second", 5, '{32'h13579BDF, 8'h24}, '{32'h12345678, 8'h00}, 1, 4 * F);
    test_boundary();
    test_update("blank_pattern", 3, '{32'h00000305, 8'h00}, '{32'h0, 8'h0}, 0, 3 * F);
    test_update("all_zero", 3, '{32'h00000000, 8'h00}, '{32'h0, 8'h0}, 0, 3 * F);
    test_update("dp_blocks_blank", 3, '{32'h00000007, 8'h20}, '{32'h0, 8'h0}, 0, 3 * F);
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
